spi_slv: RTL and testbench
==========================

Name: spi_slv

Overview:
- SPI mode-0 slave (responder) for the far end of the SPI master bus: CPOL=0, MSB-first, samples MOSI on SCLK rise, drives MISO after SCLK fall.
- Runs entirely in the clk domain. SCLK, SS_N and MOSI are oversampled through synchronizers.
- Host side loads a reply word and length, and receives the captured MOSI word plus bit count when SS_N deasserts.
- Pairs with the SPI master in loopback benches and in FPGA-to-FPGA links.

Parameters:
- SPI_MAXLEN, 32, maximum bits captured/transmitted per transaction.
- SYNC_STAGES, 2, synchronizer depth on SCLK/SS_N/MOSI (>=2).

Ports:
- clk  input  1  system clock.
- sresetn  input  1  reset, asynchronous assert, active low.
- tx_load  input  1  one-cycle strobe: capture tx_data/tx_len into shadow register.
- tx_data  input  SPI_MAXLEN  reply data; first bit sent is tx_data[tx_len-1].
- tx_len  input  $clog2(SPI_MAXLEN)+1  reply length, 0..SPI_MAXLEN.
- rx_valid  output  1  one-cycle pulse: transaction complete, rx_data/rx_nbits valid.
- rx_data  output  SPI_MAXLEN  captured MOSI; rx_data[rx_nbits-1] is the first bit, rx_data[0] the last.
- rx_nbits  output  $clog2(SPI_MAXLEN)+1  SCLK rising edges seen, saturating at SPI_MAXLEN.
- rx_ovf  output  1  more than SPI_MAXLEN rising edges in the last transaction.
- busy  output  1  SS_N (synchronized) asserted and transaction in progress.
- SCLK  input  1  SPI clock from master.
- SS_N  input  1  slave select, active low.
- MOSI  input  1  master-out data.
- MISO  output  1  slave-out data.
- MISO_OE  output  1  MISO output enable (1 while selected), for external tri-state.

Behaviour:
Reset:
- All outputs 0, including rx_data, rx_nbits, rx_ovf, MISO, MISO_OE and busy.
- Shadow tx_data=0, tx_len=0.
- Synchronizer flops reset to SS_N=1, SCLK=0, MOSI=0.
- FSM resets to WAIT_DESEL.

Timing requirements on the master side:
- SCLK high and low phases each >= SYNC_STAGES+2 clk.
- SS_N fall to first SCLK rise >= SYNC_STAGES+2 clk.
- Last SCLK fall to SS_N rise >= 2 clk.
- Outside these limits, behaviour is undefined.

Edge detect:
- On the synchronized signals, by comparing to a one-cycle-delayed copy.
- Edge pulses lag the pins by SYNC_STAGES+1 clk.

FSM:
- WAIT_DESEL: ignore the bus; go to IDLE when synced SS_N=1. Guards against reset release mid-transaction.
- IDLE: busy=0, MISO_OE=0, MISO=0. On SS_N fall:
  - copy shadow into tx shift register and bit counter;
  - clear the rx shift register, count and ovf;
  - drive MISO=tx_data[tx_len-1], or 0 if tx_len=0;
  - MISO_OE=1; go to ACTIVE.
- ACTIVE:
  - SCLK rise: rx_shift <= {rx_shift[SPI_MAXLEN-2:0], MOSI_sync}. Count increments, saturating at SPI_MAXLEN; once saturated, the next rise sets ovf. rx keeps the last SPI_MAXLEN bits.
  - SCLK fall: advance the tx pointer. MISO = next bit, or 0 once tx_len bits are exhausted. MISO is registered, updated in the same cycle the fall pulse is seen.
  - SS_N rise: rx_data/rx_nbits/rx_ovf <= shift/count/ovf, rx_valid=1 for one cycle, MISO_OE=0, MISO=0, go to IDLE.

Rules:
- SCLK edge and SS_N rise detected in the same cycle: apply the edge first, then complete.
- SS_N rise with zero SCLK edges: rx_valid pulses with rx_nbits=0.
- rx_data holds until the next rx_valid.
- tx_load is accepted in any state and updates only the shadow. It takes effect at the next SS_N fall, never mid-transaction.
- A tx_load in the same cycle as an SS_N fall: the new values are used.
- The shadow is not cleared after use; an unreloaded reply repeats.
- tx_len > SPI_MAXLEN is treated as SPI_MAXLEN.
- Asynchronous reset mid-transaction: all state is cleared immediately; after release the FSM stays in WAIT_DESEL until SS_N is high.

Decomposition:
- spi_pkg holds:
  - typedef enum logic [1:0] {WAIT_DESEL, IDLE, ACTIVE} spi_slv_state_t;
  - function cnt_w(maxlen) returning $clog2(maxlen)+1.
- One sub-module, spi_sync_edge: SYNC_STAGES-deep synchronizer with reset value parameter; outputs level, rise and fall. Instantiated for SCLK, SS_N and MOSI (MOSI uses level only).

Test Plan:
- Master model, half period 6 clk. tx_load tx_data=32'hA5, tx_len=8; master sends 8 bits 8'h3C. Expect:
  - master receives 8'hA5;
  - rx_valid one pulse, rx_data=32'h3C, rx_nbits=8, rx_ovf=0.
- 32-bit transfer, MOSI=32'hDEADBEEF, tx_data=32'h12345678/len 32. Expect both directions exact and rx_nbits=32.
- 36 SCLK pulses, MOSI=36'hF_0123_4567. Expect:
  - rx_data=32'h01234567, rx_nbits=32, rx_ovf=1;
  - master sees 0 on MISO for bits 33-36.
- SS_N low/high with no SCLK. Expect rx_valid, rx_nbits=0, MISO_OE high only during select.
- tx_load of 8'h5A mid-transaction while sending 8'hA5. Expect:
  - current transaction returns A5;
  - next transaction returns 5A;
  - a third, unreloaded transaction returns 5A again.
- Assert sresetn low mid-transaction, release while SS_N still low. Expect:
  - outputs 0, no rx_valid, bus ignored until SS_N high;
  - the next full transaction is correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI mode-0 slave.
package spi_pkg;

  typedef enum logic [1:0] {WAIT_DESEL, IDLE, ACTIVE} spi_slv_state_t;

  function automatic int cnt_w(input int maxlen);
    return $clog2(maxlen) + 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with a delayed copy for rise/fall pulse generation.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic sresetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_slv.sv
// SPI mode-0 slave running in the clk domain: oversampled bus, shadowed reply,
// captured MOSI word and bit count reported when the master deselects.
module spi_slv
  import spi_pkg::*;
#(
  parameter int  SPI_MAXLEN  = 32,
  parameter int  SYNC_STAGES = 2,
  localparam int CW          = cnt_w(SPI_MAXLEN)
) (
  input  logic                  clk,
  input  logic                  sresetn,
  input  logic                  tx_load,
  input  logic [SPI_MAXLEN-1:0] tx_data,
  input  logic [CW-1:0]         tx_len,
  output logic                  rx_valid,
  output logic [SPI_MAXLEN-1:0] rx_data,
  output logic [CW-1:0]         rx_nbits,
  output logic                  rx_ovf,
  output logic                  busy,
  input  logic                  SCLK,
  input  logic                  SS_N,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE
);

  logic sclk_rise, sclk_fall, unused_sclk_lvl;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .sresetn(sresetn), .din(SCLK),
    .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .sresetn(sresetn), .din(SS_N),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .sresetn(sresetn), .din(MOSI),
    .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  spi_slv_state_t          state_q, state_d;
  logic [7:0]              wd_cnt_q, wd_cnt_d;
  logic [SPI_MAXLEN-1:0]   sh_data_q, sh_data_d;
  logic [CW-1:0]           sh_len_q, sh_len_d;
  logic [SPI_MAXLEN-1:0]   tx_shift_q, tx_shift_d;
  logic [SPI_MAXLEN-1:0]   rx_shift_q, rx_shift_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic [SPI_MAXLEN-1:0]   rx_data_q, rx_data_d;
  logic [CW-1:0]           rx_nbits_q, rx_nbits_d;
  logic                    rx_ovf_q, rx_ovf_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    miso_q, miso_d;
  logic                    miso_oe_q, miso_oe_d;

  logic [SPI_MAXLEN-1:0]   data_eff;
  logic [CW-1:0]           len_eff, shamt;

  always_comb begin
    state_d    = state_q;
    wd_cnt_d   = wd_cnt_q;
    sh_data_d  = sh_data_q;
    sh_len_d   = sh_len_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    rx_data_d  = rx_data_q;
    rx_nbits_d = rx_nbits_q;
    rx_ovf_d   = rx_ovf_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;

    if (tx_load) begin
      sh_data_d = tx_data;
      sh_len_d  = tx_len;
    end

    // Reply is left-aligned so bits beyond tx_len are shifted-in zeros.
    data_eff = tx_load ? tx_data : sh_data_q;
    len_eff  = tx_load ? tx_len  : sh_len_q;
    if (len_eff > CW'(SPI_MAXLEN))
      len_eff = CW'(SPI_MAXLEN);
    shamt = CW'(SPI_MAXLEN) - len_eff;

    case (state_q)
      WAIT_DESEL: begin
        // Synchronizer resets to "deselected"; require SS_N high for longer than
        // the pipeline depth so a real low pin cannot sneak through as a fall.
        if (ss_lvl) begin
          if (wd_cnt_q == 8'(SYNC_STAGES)) begin
            state_d  = IDLE;
            wd_cnt_d = '0;
          end else begin
            wd_cnt_d = wd_cnt_q + 8'd1;
          end
        end else begin
          wd_cnt_d = '0;
        end
      end

      IDLE: begin
        if (ss_fall) begin
          tx_shift_d = data_eff << shamt;
          rx_shift_d = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          miso_d     = tx_shift_d[SPI_MAXLEN-1];
          miso_oe_d  = 1'b1;
          state_d    = ACTIVE;
        end
      end

      ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[SPI_MAXLEN-2:0], mosi_lvl};
          if (cnt_q == CW'(SPI_MAXLEN))
            ovf_d = 1'b1;
          else
            cnt_d = cnt_q + CW'(1);
        end
        if (sclk_fall) begin
          tx_shift_d = tx_shift_q << 1;
          miso_d     = tx_shift_q[SPI_MAXLEN-2];
        end
        if (ss_rise) begin
          rx_data_d  = rx_shift_d;
          rx_nbits_d = cnt_d;
          rx_ovf_d   = ovf_d;
          rx_valid_d = 1'b1;
          miso_d     = 1'b0;
          miso_oe_d  = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = WAIT_DESEL;
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q    <= WAIT_DESEL;
      wd_cnt_q   <= '0;
      sh_data_q  <= '0;
      sh_len_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_nbits_q <= '0;
      rx_ovf_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_cnt_q   <= wd_cnt_d;
      sh_data_q  <= sh_data_d;
      sh_len_q   <= sh_len_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rx_data_q  <= rx_data_d;
      rx_nbits_q <= rx_nbits_d;
      rx_ovf_q   <= rx_ovf_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_nbits = rx_nbits_q;
  assign rx_ovf   = rx_ovf_q;
  assign busy     = (state_q == ACTIVE);
  assign MISO     = miso_q;
  assign MISO_OE  = miso_oe_q;

endmodule

// File: tb/tb_spi_slv.sv
// Directed bench for spi_slv: a mode-0 master model with hand-computed replies.
module tb_spi_slv;

  localparam int MAXLEN = 32;
  localparam int CW     = 6;

  logic              clk = 1'b0;
  logic              sresetn = 1'b1;
  logic              tx_load = 1'b0;
  logic [MAXLEN-1:0] tx_data = '0;
  logic [CW-1:0]     tx_len = '0;
  logic              rx_valid;
  logic [MAXLEN-1:0] rx_data;
  logic [CW-1:0]     rx_nbits;
  logic              rx_ovf;
  logic              busy;
  logic              SCLK = 1'b0;
  logic              SS_N = 1'b1;
  logic              MOSI = 1'b0;
  logic              MISO;
  logic              MISO_OE;

  spi_slv #(.SPI_MAXLEN(MAXLEN), .SYNC_STAGES(2)) dut (
    .clk(clk), .sresetn(sresetn), .tx_load(tx_load), .tx_data(tx_data),
    .tx_len(tx_len), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_nbits(rx_nbits), .rx_ovf(rx_ovf), .busy(busy), .SCLK(SCLK),
    .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int vcnt  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rx_valid === 1'b1) vcnt++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [MAXLEN-1:0] d, input logic [CW-1:0] l);
    tx_data = d;
    tx_len  = l;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
  endtask

  // Master: half period 6 clk, MOSI set while SCLK low, MISO sampled at the rise.
  task automatic xfer(input int nbits, input logic [63:0] mosi_w, output logic [63:0] miso_w);
    miso_w = '0;
    SS_N = 1'b0;
    wait_clk(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      MOSI = mosi_w[i];
      wait_clk(6);
      miso_w = {miso_w[62:0], MISO};
      SCLK = 1'b1;
      wait_clk(6);
      SCLK = 1'b0;
    end
    wait_clk(6);
    SS_N = 1'b1;
    MOSI = 1'b0;
  endtask

  logic [63:0] m;
  int          v0;

  initial begin
    #2 sresetn = 1'b0;
    wait_clk(4);
    chk("rst_busy", busy, 0);
    chk("rst_oe", MISO_OE, 0);
    chk("rst_miso", MISO, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_nbits", rx_nbits, 0);
    chk("rst_ovf", rx_ovf, 0);
    sresetn = 1'b1;
    wait_clk(10);

    // 8-bit exchange
    load(32'hA5, 6'd8);
    v0 = vcnt;
    xfer(8, 64'h3C, m);
    wait_clk(12);
    chk("t1_miso", m, 64'hA5);
    chk("t1_vcnt", 64'(vcnt - v0), 1);
    chk("t1_data", rx_data, 32'h3C);
    chk("t1_nbits", rx_nbits, 8);
    chk("t1_ovf", rx_ovf, 0);

    // full-width exchange
    load(32'h12345678, 6'd32);
    v0 = vcnt;
    xfer(32, 64'hDEADBEEF, m);
    wait_clk(12);
    chk("t2_miso", m, 64'h12345678);
    chk("t2_vcnt", 64'(vcnt - v0), 1);
    chk("t2_data", rx_data, 32'hDEADBEEF);
    chk("t2_nbits", rx_nbits, 32);
    chk("t2_ovf", rx_ovf, 0);

    // overflow: 36 clocks, reply exhausted after 32
    v0 = vcnt;
    xfer(36, 64'hF_0123_4567, m);
    wait_clk(12);
    chk("t3_miso", m, 64'h1_2345_6780);
    chk("t3_vcnt", 64'(vcnt - v0), 1);
    chk("t3_data", rx_data, 32'h01234567);
    chk("t3_nbits", rx_nbits, 32);
    chk("t3_ovf", rx_ovf, 1);

    // select with no clocks
    v0 = vcnt;
    chk("t4_oe_before", MISO_OE, 0);
    SS_N = 1'b0;
    wait_clk(8);
    chk("t4_oe_sel", MISO_OE, 1);
    chk("t4_busy_sel", busy, 1);
    SS_N = 1'b1;
    wait_clk(8);
    chk("t4_oe_after", MISO_OE, 0);
    chk("t4_busy_after", busy, 0);
    chk("t4_vcnt", 64'(vcnt - v0), 1);
    chk("t4_nbits", rx_nbits, 0);
    chk("t4_ovf", rx_ovf, 0);

    // reload mid-transaction applies only to the next select
    load(32'hA5, 6'd8);
    fork
      xfer(8, 64'h11, m);
      begin
        wait_clk(40);
        load(32'h5A, 6'd8);
      end
    join
    wait_clk(12);
    chk("t5_cur", m, 64'hA5);
    chk("t5_cur_rx", rx_data, 32'h11);
    xfer(8, 64'h22, m);
    wait_clk(12);
    chk("t5_next", m, 64'h5A);
    xfer(8, 64'h33, m);
    wait_clk(12);
    chk("t5_repeat", m, 64'h5A);
    chk("t5_repeat_rx", rx_data, 32'h33);

    // reset in the middle of a transaction
    load(32'hA5, 6'd8);
    v0 = vcnt;
    fork
      xfer(8, 64'hFF, m);
      begin
        wait_clk(40);
        sresetn = 1'b0;
        wait_clk(2);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_oe", MISO_OE, 0);
        chk("t6_rst_miso", MISO, 0);
        chk("t6_rst_data", rx_data, 0);
        chk("t6_rst_nbits", rx_nbits, 0);
        sresetn = 1'b1;
        wait_clk(20);
        chk("t6_ign_busy", busy, 0);
        chk("t6_ign_oe", MISO_OE, 0);
      end
    join
    wait_clk(12);
    chk("t6_no_valid", 64'(vcnt - v0), 0);
    chk("t6_data_kept0", rx_data, 0);
    load(32'hC3, 6'd8);
    v0 = vcnt;
    xfer(8, 64'h96, m);
    wait_clk(12);
    chk("t6_miso", m, 64'hC3);
    chk("t6_vcnt", 64'(vcnt - v0), 1);
    chk("t6_data", rx_data, 32'h96);
    chk("t6_nbits", rx_nbits, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
